// File: rtl/mp_sub_seq.sv
// Multi-precision subtract sequencer: streams 32-bit limb pairs (LS limb first)
// through a borrow-chain subtractor and registers each difference limb onto a valid/ready stream.

module mp_sub_seq_sub32 (
    input  logic        i_en,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_bin,
    output logic [31:0] o_diff,
    output logic        o_bout
);
    logic [32:0] w_full;

    // Bit 32 of the zero-extended difference is the borrow-out.
    assign w_full = i_en ? ({1'b0, i_a} - {1'b0, i_b} - {32'd0, i_bin}) : 33'd0;
    assign o_diff = w_full[31:0];
    assign o_bout = w_full[32];
endmodule

module mp_sub_seq #(
    parameter int MAX_LIMBS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_diff,
    output logic        out_last,
    output logic        out_borrow,
    output logic        out_zero,
    output logic        out_err
);
    localparam int CW = $clog2(MAX_LIMBS + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t          r_state;
    logic            r_borrow;
    logic            r_zacc;
    logic [CW-1:0]   r_count;

    logic            r_out_valid;
    logic [31:0]     r_out_diff;
    logic            r_out_last;
    logic            r_out_borrow;
    logic            r_out_zero;
    logic            r_out_err;

    logic            w_accept;
    logic            w_first;
    logic            w_bin;
    logic [31:0]     w_diff;
    logic            w_bout;
    logic [CW-1:0]   w_count_nxt;
    logic            w_zacc_nxt;
    logic            w_terminal;

    mp_sub_seq_sub32 u_sub (
        .i_en   (1'b1),
        .i_a    (in_a),
        .i_b    (in_b),
        .i_bin  (w_bin),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );

    // Single output register, no skid: a held output blocks the input directly.
    assign in_ready    = ~r_out_valid | out_ready;
    assign w_accept    = in_valid & in_ready;
    assign w_first     = (r_state == S_IDLE);
    assign w_bin       = w_first ? 1'b0 : r_borrow;
    assign w_count_nxt = w_first ? CW'(1) : r_count + CW'(1);
    assign w_zacc_nxt  = (w_first | r_zacc) & (w_diff == 32'd0);
    // Hitting the limb limit without in_last forces the operation to close.
    assign w_terminal  = in_last | (w_count_nxt == CW'(MAX_LIMBS));

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_borrow     <= 1'b0;
            r_zacc       <= 1'b0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_out_diff   <= 32'd0;
            r_out_last   <= 1'b0;
            r_out_borrow <= 1'b0;
            r_out_zero   <= 1'b0;
            r_out_err    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_diff   <= w_diff;
            r_out_last   <= w_terminal;
            r_out_borrow <= w_terminal & w_bout;
            r_out_zero   <= w_terminal & w_zacc_nxt;
            r_out_err    <= w_terminal & ~in_last;
            if (w_terminal) begin
                r_state  <= S_IDLE;
                r_borrow <= 1'b0;
                r_zacc   <= 1'b0;
                r_count  <= '0;
            end else begin
                r_state  <= S_BUSY;
                r_borrow <= w_bout;
                r_zacc   <= w_zacc_nxt;
                r_count  <= w_count_nxt;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_diff   = r_out_diff;
    assign out_last   = r_out_last;
    assign out_borrow = r_out_borrow;
    assign out_zero   = r_out_zero;
    assign out_err    = r_out_err;
endmodule

// File: tb/tb_mp_sub_seq.sv
// Self-checking bench for mp_sub_seq: directed steps plus random ops, with a
// scoreboard of expected limbs filled on input accept and drained on output handshake.
`timescale 1ns/1ps

module tb_mp_sub_seq;
    localparam int MAXL = 4;

    typedef struct {
        logic [31:0] diff;
        logic        last;
        logic        borrow;
        logic        zero;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_diff;
    logic        out_last;
    logic        out_borrow;
    logic        out_zero;
    logic        out_err;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    logic        m_busy;
    logic        m_borrow;
    logic        m_zacc;
    int          m_count;

    mp_sub_seq #(.MAX_LIMBS(MAXL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_last   (out_last),
        .out_borrow (out_borrow),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_borrow = 1'b0;
        m_zacc   = 1'b0;
        m_count  = 0;
    endtask

    // Reference behaviour of one accepted limb; borrow derived by comparison.
    task automatic model_accept(input logic [31:0] a, input logic [31:0] b, input logic last);
        exp_t        e;
        logic        bin;
        logic        bout;
        logic [31:0] d;
        int          cnt;
        logic        zacc;
        logic        term;
        bin  = m_busy ? m_borrow : 1'b0;
        d    = a - b - {31'd0, bin};
        bout = (a < b) || ((a == b) && bin);
        cnt  = m_busy ? m_count + 1 : 1;
        zacc = (m_busy ? m_zacc : 1'b1) && (d == 32'd0);
        term = last || (cnt == MAXL);
        e.diff   = d;
        e.last   = term;
        e.borrow = term && bout;
        e.zero   = term && zacc;
        e.err    = term && !last;
        sb.push_back(e);
        if (term) begin
            model_reset();
        end else begin
            m_busy   = 1'b1;
            m_borrow = bout;
            m_zacc   = zacc;
            m_count  = cnt;
        end
    endtask

    // Presents one limb and holds it until accepted; returns at posedge+1 after the accept edge.
    task automatic send_limb(input logic [31:0] a, input logic [31:0] b, input logic last,
                             input logic rnd);
        logic accepted;
        accepted = 1'b0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(a, b, last);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted) break;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        check("accept_timeout", {31'd0, accepted}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("idle_valid", {31'd0, out_valid}, 32'd0);
    endtask

    // Output monitor: compares each handshaken limb against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff",   out_diff, e.diff);
                check("last",   {31'd0, out_last},   {31'd0, e.last});
                check("borrow", {31'd0, out_borrow}, {31'd0, e.borrow});
                check("zero",   {31'd0, out_zero},   {31'd0, e.zero});
                check("err",    {31'd0, out_err},    {31'd0, e.err});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          nl;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_reset();

        #12;
        check("rst_valid",  {31'd0, out_valid},  32'd0);
        check("rst_diff",   out_diff,            32'd0);
        check("rst_last",   {31'd0, out_last},   32'd0);
        check("rst_borrow", {31'd0, out_borrow}, 32'd0);
        check("rst_zero",   {31'd0, out_zero},   32'd0);
        check("rst_err",    {31'd0, out_err},    32'd0);
        check("rst_ready",  {31'd0, in_ready},   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-limb ops: 5-3 and 3-5.
        send_limb(32'd5, 32'd3, 1'b1, 1'b0);
        send_limb(32'd3, 32'd5, 1'b1, 1'b0);
        drain();

        // Two-limb op with inter-limb borrow, back-to-back with an all-equal op.
        send_limb(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        send_limb(32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        send_limb(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        send_limb(32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0);
        drain();

        // Backpressure: consumer stalls 3 cycles with the next limb pending.
        send_limb(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_a      = 32'h0000_0010;
        in_b      = 32'h0000_0005;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_diff", out_diff,           32'hFFFF_FFFF);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_limb(32'h0000_0010, 32'h0000_0005, 1'b1, 1'b0);
        drain();

        // Limb-count overflow: five limbs without in_last, then close the fresh op.
        for (int i = 0; i < 5; i++) send_limb(32'd0, 32'd1, 1'b0, 1'b0);
        send_limb(32'd9, 32'd2, 1'b1, 1'b0);
        drain();

        // Reset after the first limb of a borrowing op.
        send_limb(32'd0, 32'd1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  {31'd0, out_valid},  32'd0);
        check("mid_rst_diff",   out_diff,            32'd0);
        check("mid_rst_last",   {31'd0, out_last},   32'd0);
        check("mid_rst_borrow", {31'd0, out_borrow}, 32'd0);
        check("mid_rst_ready",  {31'd0, in_ready},   32'd1);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_limb(32'd10, 32'd4, 1'b1, 1'b0);
        drain();

        // Random ops of 1..8 limbs with random consumer backpressure.
        for (int op = 0; op < 1000; op++) begin
            nl = $urandom_range(1, 8);
            for (int l = 0; l < nl; l++) begin
                ra = $urandom;
                rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                send_limb(ra, rb, (l == nl - 1), 1'b1);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
